// File: rtl/comm_pkg.sv
// Shared constants, state encoding and CRC-32 step function for the miner link framing.
package comm_pkg;

    // Message-type constants (PING is a bare byte; the rest are header byte 3).
    localparam logic [7:0] MSG_PING     = 8'h00;
    localparam logic [7:0] MSG_GET_INFO = 8'h00;
    localparam logic [7:0] MSG_INVALID  = 8'h01;
    localparam logic [7:0] MSG_PUSH_JOB = 8'h02;
    localparam logic [7:0] MSG_NONCE    = 8'h03;

    // err_code values.
    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BAD_LEN = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_CRC     = 3'd3;
    localparam logic [2:0] ERR_OVERRUN = 3'd4;

    localparam int unsigned HDR_LEN = 4;
    localparam int unsigned CRC_LEN = 4;

    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StBody,
        StCrc,
        StDone
    } rx_state_e;

    // One byte of reflected CRC-32; the caller owns init and final XOR.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/comm_crc32.sv
// Byte-serial CRC-32 register. Clear reloads the init value; clear together with
// enable seeds the register with the first byte in the same cycle.
module comm_crc32
    import comm_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_base;

    assign w_base = i_clear ? CRC_INIT : r_crc;

    // Running CRC state, advanced one byte per enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc32_byte(w_base, i_byte);
        end else if (i_clear) begin
            r_crc <= CRC_INIT;
        end
    end

    // Final XOR applied here so callers compare against the transmitted value directly.
    assign o_crc = r_crc ^ CRC_XOROUT;

endmodule

// File: rtl/comm_frame_rx.sv
// Length-prefixed frame receiver: header/payload assembly, length, timeout and CRC checks,
// double-buffered payload output with valid/ready, PING detection and error reporting.
module comm_frame_rx
    import comm_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned MIN_LEN        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    parameter int unsigned PAYLOAD_W      = (MAX_LEN - 8) * 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_valid,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [7:0]           frame_type,
    output logic [7:0]           frame_len,
    output logic [PAYLOAD_W-1:0] frame_payload,
    output logic                 ping,
    output logic                 err_valid,
    output logic [2:0]           err_code
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  MIN_B = 8'(MIN_LEN);
    localparam logic [7:0]  MAX_B = 8'(MAX_LEN);

    rx_state_e            r_state;
    logic [7:0]           r_len;
    logic [7:0]           r_cnt;
    logic [7:0]           r_type;
    logic [PAYLOAD_W-1:0] r_stage;
    logic [31:0]          r_rx_crc;
    logic [TMO_W-1:0]     r_tmo;

    logic                 r_frame_valid;
    logic [7:0]           r_frame_type;
    logic [7:0]           r_frame_len;
    logic [PAYLOAD_W-1:0] r_frame_payload;
    logic                 r_ping;
    logic                 r_err_valid;
    logic [2:0]           r_err_code;

    logic        w_idle_like;
    logic        w_in_frame;
    logic        w_is_ping;
    logic        w_bad_len;
    logic        w_start;
    logic        w_crc_en;
    logic        w_crc_match;
    logic        w_tmo_hit;
    logic [7:0]  w_stage_idx;
    logic [31:0] w_crc;

    // DONE lasts one cycle and also accepts a new first byte, so it decodes like IDLE.
    assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
    assign w_in_frame  = (r_state == StHdr) || (r_state == StBody) || (r_state == StCrc);
    assign w_is_ping   = (rx_byte == MSG_PING);
    assign w_bad_len   = (rx_byte < MIN_B) || (rx_byte > MAX_B);
    assign w_start     = rx_valid && w_idle_like && !w_is_ping && !w_bad_len;
    assign w_crc_en    = w_start || (rx_valid && ((r_state == StHdr) || (r_state == StBody)));
    assign w_crc_match = (r_rx_crc == w_crc);
    assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYCLES));
    assign w_stage_idx = r_cnt - 8'(HDR_LEN);

    comm_crc32 u_crc (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_clear (w_start),
        .i_en    (w_crc_en),
        .i_byte  (rx_byte),
        .o_crc   (w_crc)
    );

    // Frame FSM with registered outputs, handshake and error pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state         <= StIdle;
            r_len           <= '0;
            r_cnt           <= '0;
            r_type          <= '0;
            r_stage         <= '0;
            r_rx_crc        <= '0;
            r_tmo           <= '0;
            r_frame_valid   <= 1'b0;
            r_frame_type    <= '0;
            r_frame_len     <= '0;
            r_frame_payload <= '0;
            r_ping          <= 1'b0;
            r_err_valid     <= 1'b0;
            r_err_code      <= ERR_NONE;
        end else begin
            r_ping      <= 1'b0;
            r_err_valid <= 1'b0;
            if (r_frame_valid && frame_ready) begin
                r_frame_valid <= 1'b0;
            end

            unique case (r_state)
                StIdle, StDone: begin
                    r_state <= StIdle;
                    if (rx_valid) begin
                        if (w_is_ping) begin
                            r_ping <= 1'b1;
                        end else if (w_bad_len) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_BAD_LEN;
                        end else begin
                            r_len   <= rx_byte;
                            r_cnt   <= 8'd1;
                            r_tmo   <= '0;
                            r_stage <= '0;
                            r_state <= StHdr;
                        end
                    end
                    // Frame verdict comes last so it wins over a same-cycle byte error.
                    if (r_state == StDone) begin
                        if (!w_crc_match) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_CRC;
                        end else if (r_frame_valid) begin
                            r_err_valid <= 1'b1;
                            r_err_code  <= ERR_OVERRUN;
                        end else begin
                            r_frame_valid   <= 1'b1;
                            r_frame_len     <= r_len;
                            r_frame_type    <= r_type;
                            r_frame_payload <= r_stage;
                        end
                    end
                end
                StHdr: begin
                    if (rx_valid) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == 8'(HDR_LEN - 1)) begin
                            r_type  <= rx_byte;
                            r_state <= (r_len == 8'(HDR_LEN + CRC_LEN)) ? StCrc : StBody;
                        end
                    end
                end
                StBody: begin
                    if (rx_valid) begin
                        r_stage[{w_stage_idx, 3'b000} +: 8] <= rx_byte;
                        r_cnt <= r_cnt + 8'd1;
                        if (r_cnt == r_len - 8'(CRC_LEN + 1)) begin
                            r_state <= StCrc;
                        end
                    end
                end
                StCrc: begin
                    if (rx_valid) begin
                        r_rx_crc <= {rx_byte, r_rx_crc[31:8]};
                        r_cnt    <= r_cnt + 8'd1;
                        if (r_cnt == r_len - 8'd1) begin
                            r_state <= StDone;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase

            // Inter-byte timeout; overrides the state chosen above and drops the partial frame.
            if (w_in_frame) begin
                if (rx_valid) begin
                    r_tmo <= '0;
                end else if (w_tmo_hit) begin
                    r_tmo       <= '0;
                    r_err_valid <= 1'b1;
                    r_err_code  <= ERR_TIMEOUT;
                    r_state     <= StIdle;
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
            end
        end
    end

    assign frame_valid   = r_frame_valid;
    assign frame_type    = r_frame_type;
    assign frame_len     = r_frame_len;
    assign frame_payload = r_frame_payload;
    assign ping          = r_ping;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;

endmodule

// File: tb/tb_comm_frame_rx.sv
// Directed bench for comm_frame_rx: frames are built byte by byte with a bit-serial CRC-32
// model; expected payloads come from the bytes the bench itself sends.
module tb_comm_frame_rx;

    localparam int unsigned MAX_LEN = 64;
    localparam int unsigned MIN_LEN = 8;
    localparam int unsigned TMO     = 2048;
    localparam int unsigned PW      = (MAX_LEN - 8) * 8;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic          frame_ready = 1'b0;
    logic          frame_valid;
    logic [7:0]    frame_type;
    logic [7:0]    frame_len;
    logic [PW-1:0] frame_payload;
    logic          ping;
    logic          err_valid;
    logic [2:0]    err_code;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]    fb [0:63];
    logic [PW-1:0] exp_pl;

    always #5 CLK = ~CLK;

    comm_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .MIN_LEN        (MIN_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_type    (frame_type),
        .frame_len     (frame_len),
        .frame_payload (frame_payload),
        .ping          (ping),
        .err_valid     (err_valid),
        .err_code      (err_code)
    );

    // Reflected CRC-32 over fb[0..n-1], one message bit at a time.
    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ fb[i][j]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int len, input logic [7:0] typ, input logic [7:0] seed);
        fb[0] = 8'(len);
        fb[1] = 8'h00;
        fb[2] = 8'h00;
        fb[3] = typ;
        for (int i = 0; i < len - 8; i++) fb[4 + i] = 8'(int'(seed) + i * 7);
    endtask

    // Records the expected payload and appends the CRC, LSB first.
    task automatic finish_frame(input int len);
        logic [31:0] crc;
        exp_pl = '0;
        for (int i = 0; i < len - 8; i++) exp_pl[8 * i +: 8] = fb[4 + i];
        crc = model_crc(len - 4);
        for (int k = 0; k < 4; k++) fb[len - 4 + k] = crc[8 * k +: 8];
    endtask

    // Drives one byte for one cycle; returns #1 after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i]);
            if (i != n - 1) begin
                @(posedge CLK);
                #1;
            end
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
        tests_run++;
        if ({ping, err_valid} !== 2'b00) begin tests_failed++; $display("FAIL reset_pulses: ping/err got %b want 00", {ping, err_valid}); end
        tests_run++;
        if (err_code !== 3'd0) begin tests_failed++; $display("FAIL reset_code: got %0d want 0", err_code); end
        tests_run++;
        if ({frame_len, frame_type} !== 16'h0000) begin tests_failed++; $display("FAIL reset_hdr: got %h want 0000", {frame_len, frame_type}); end
        tests_run++;
        if (frame_payload !== '0) begin tests_failed++; $display("FAIL reset_payload: got %h want 0", frame_payload); end
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_ping;
        send_byte(8'h00);
        tests_run++;
        if ({ping, err_valid, frame_valid} !== 3'b100) begin tests_failed++; $display("FAIL ping_pulse: ping/err/valid got %b want 100", {ping, err_valid, frame_valid}); end
        step();
        tests_run++;
        if (ping !== 1'b0) begin tests_failed++; $display("FAIL ping_once: got %b want 0", ping); end
    endtask

    task automatic test_min_frame;
        build_frame(8, 8'h00, 8'h00);
        finish_frame(8);
        send_frame(8);
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL min_latency: frame_valid got %b want 0 one cycle after last byte", frame_valid); end
        step();
        tests_run++;
        if ({frame_valid, err_valid} !== 2'b10) begin tests_failed++; $display("FAIL min_valid: valid/err got %b want 10", {frame_valid, err_valid}); end
        tests_run++;
        if ({frame_len, frame_type} !== 16'h0800) begin tests_failed++; $display("FAIL min_hdr: got %h want 0800", {frame_len, frame_type}); end
        tests_run++;
        if (frame_payload !== '0) begin tests_failed++; $display("FAIL min_payload: got %h want 0", frame_payload); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL min_release: got %b want 0", frame_valid); end
    endtask

    task automatic test_bad_len;
        send_byte(8'h06);
        tests_run++;
        if ({err_valid, err_code} !== 4'b1001) begin tests_failed++; $display("FAIL badlen_short: err/code got %b want 1001", {err_valid, err_code}); end
        step();
        tests_run++;
        if (err_valid !== 1'b0) begin tests_failed++; $display("FAIL badlen_pulse: got %b want 0", err_valid); end
        send_byte(8'(MAX_LEN + 1));
        tests_run++;
        if ({err_valid, err_code} !== 4'b1001) begin tests_failed++; $display("FAIL badlen_long: err/code got %b want 1001", {err_valid, err_code}); end
        step();
        build_frame(8, 8'h01, 8'h00);
        finish_frame(8);
        send_frame(8);
        step();
        tests_run++;
        if ({frame_valid, frame_type, err_code} !== {1'b1, 8'h01, 3'd1}) begin tests_failed++; $display("FAIL badlen_recover: valid/type/code got %b/%h/%0d want 1/01/1", frame_valid, frame_type, err_code); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic test_max_len;
        build_frame(MAX_LEN, 8'h03, 8'h11);
        finish_frame(MAX_LEN);
        send_frame(MAX_LEN);
        step();
        tests_run++;
        if ({frame_valid, frame_len} !== {1'b1, 8'(MAX_LEN)}) begin tests_failed++; $display("FAIL max_valid: valid/len got %b/%0d want 1/%0d", frame_valid, frame_len, MAX_LEN); end
        tests_run++;
        if (frame_payload !== exp_pl) begin tests_failed++; $display("FAIL max_payload: got %h want %h", frame_payload, exp_pl); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        bit early_valid;
        build_frame(8, 8'h00, 8'h00);
        finish_frame(8);
        send_frame(7);
        seen = 1'b0;
        early_valid = 1'b0;
        n = 0;
        while (!seen && n < int'(TMO) + 16) begin
            step();
            n++;
            if (frame_valid) early_valid = 1'b1;
            if (err_valid) seen = 1'b1;
        end
        tests_run++;
        if (!seen || err_code !== 3'd2) begin tests_failed++; $display("FAIL tmo_fire: seen=%b code=%0d want seen=1 code=2", seen, err_code); end
        tests_run++;
        if (n < int'(TMO) - 1 || n > int'(TMO) + 2) begin tests_failed++; $display("FAIL tmo_cycles: fired after %0d idle cycles want about %0d", n, TMO); end
        tests_run++;
        if (early_valid !== 1'b0) begin tests_failed++; $display("FAIL tmo_discard: frame_valid seen %b want 0", early_valid); end
        step();
        send_frame(8);
        step();
        tests_run++;
        if ({frame_valid, frame_len} !== {1'b1, 8'd8}) begin tests_failed++; $display("FAIL tmo_recover: valid/len got %b/%0d want 1/8", frame_valid, frame_len); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic build_push_job;
        build_frame(60, 8'h02, 8'h10);
        fb[52] = 8'h7B;
        fb[53] = 8'h2B;
        fb[54] = 8'hAC;
        fb[55] = 8'h1D;
        finish_frame(60);
    endtask

    task automatic test_push_job;
        build_push_job();
        send_frame(60);
        step();
        tests_run++;
        if ({frame_valid, frame_type, frame_len} !== {1'b1, 8'h02, 8'd60}) begin tests_failed++; $display("FAIL job_hdr: valid/type/len got %b/%h/%0d want 1/02/60", frame_valid, frame_type, frame_len); end
        tests_run++;
        if (frame_payload !== exp_pl) begin tests_failed++; $display("FAIL job_payload: got %h want %h", frame_payload, exp_pl); end
        tests_run++;
        if (frame_payload[384 +: 64] !== 64'h0000_0000_1DAC_2B7B) begin tests_failed++; $display("FAIL job_nonce: bytes 48..55 got %h want 000000001dac2b7b", frame_payload[384 +: 64]); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    task automatic test_crc_error;
        build_push_job();
        fb[20] = fb[20] ^ 8'h01;
        send_frame(60);
        tests_run++;
        if (err_valid !== 1'b0) begin tests_failed++; $display("FAIL crc_latency: err_valid got %b want 0 one cycle after last byte", err_valid); end
        step();
        tests_run++;
        if ({err_valid, err_code, frame_valid} !== 5'b1_011_0) begin tests_failed++; $display("FAIL crc_err: err/code/valid got %b/%0d/%b want 1/3/0", err_valid, err_code, frame_valid); end
    endtask

    task automatic test_overrun;
        logic [PW-1:0] exp_a;
        build_frame(9, 8'h03, 8'hA5);
        finish_frame(9);
        exp_a = exp_pl;
        send_frame(9);
        step();
        tests_run++;
        if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL ovr_first: got %b want 1", frame_valid); end
        step();
        build_frame(8, 8'h01, 8'h00);
        finish_frame(8);
        send_frame(8);
        step();
        tests_run++;
        if ({err_valid, err_code, frame_valid} !== 5'b1_100_1) begin tests_failed++; $display("FAIL ovr_err: err/code/valid got %b/%0d/%b want 1/4/1", err_valid, err_code, frame_valid); end
        tests_run++;
        if ({frame_len, frame_type} !== 16'h0903 || frame_payload !== exp_a) begin tests_failed++; $display("FAIL ovr_hold: hdr %h payload %h want 0903 %h", {frame_len, frame_type}, frame_payload, exp_a); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_release: got %b want 0", frame_valid); end
    endtask

    task automatic test_reset_midframe;
        bit any_err;
        build_frame(12, 8'h02, 8'h40);
        finish_frame(12);
        send_frame(6);
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        any_err = 1'b0;
        repeat (4) begin
            step();
            if (err_valid) any_err = 1'b1;
        end
        tests_run++;
        if (any_err !== 1'b0) begin tests_failed++; $display("FAIL rst_silent: err_valid seen %b want 0", any_err); end
        send_frame(12);
        step();
        tests_run++;
        if ({frame_valid, frame_len} !== {1'b1, 8'd12} || frame_payload !== exp_pl) begin tests_failed++; $display("FAIL rst_recover: valid/len %b/%0d payload %h want 1/12 %h", frame_valid, frame_len, frame_payload, exp_pl); end
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ping();
        test_min_frame();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_push_job();
        test_crc_error();
        test_overrun();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
